risc_alu: RTL and testbench
===========================

Name: risc_alu

Overview:
- 16-bit registered ALU for the RISC processor execute stage.
- Computes one of eight operations on operands A and B, selected by a 3-bit ALUop.
- Result and zero/negative status flags are registered on the rising clock edge, then consumed by writeback and branch logic.
- The free-running clock comes from the processor clock generator.

Parameters:
- WIDTH, 16, operand/result width in bits; shift amount uses the low log2(WIDTH) bits of B.

Ports:
- clk  input  1  system clock (driven by the clock generator); all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- ALUop  input  3  operation select
- Output  output  WIDTH  registered result
- flag_zero  output  1  registered: 1 when the registered result is all zeros
- flag_negative  output  1  registered: copy of the result MSB

Behaviour:
- Reset: while rst_n=0, Output=0, flag_zero=1, flag_negative=0, asynchronously and regardless of clk.
- Reset deassertion is sampled normally; the first result appears at the first rising edge after rst_n=1.
- Latency: 1 cycle. A, B and ALUop are sampled at rising edge N; results are visible after edge N.
- A new operation may be issued every cycle; there is no handshake or stall.
- ALUop encoding (shared constants ALU_AND/ALU_ADD/ALU_SUB etc.):
  - 000 ALU_AND: A & B
  - 001 ALU_ADD: A + B, modulo 2^WIDTH, carry discarded
  - 010 ALU_SUB: A - B, two's complement, modulo 2^WIDTH, borrow discarded
  - 011 ALU_OR: A | B
  - 100 ALU_XOR: A ^ B
  - 101 ALU_SLL: A << B[3:0], logical; zeros shifted in
  - 110 ALU_SRL: A >> B[3:0], logical; zeros shifted in
  - 111 ALU_PASSB: B (used for load-immediate)
- Shift by 0 returns A unchanged. Upper bits of B above [3:0] are ignored for shifts.
- flag_zero and flag_negative are computed from the same combinational result that is registered into Output, so flags and Output always change together on the same edge.
- Wrap-around:
  - 0xFFFF + 1 gives Output=0, flag_zero=1.
  - 0x8000 - 1 gives 0x7FFF, flag_negative=0.
- X/undefined ALUop is not a valid input; any encoding outside the list cannot occur because all 3-bit codes are defined.
- Reset asserted mid-stream: the output clears immediately, and the in-flight operation is discarded.

Optional Feature:
- Macro ALU_CARRY_FLAGS_EN.
- When defined, two extra registered outputs exist, same reset (0) and latency as the other flags:
  - flag_carry (1 bit): carry-out of ADD, or NOT borrow for SUB (1 when A >= B unsigned); 0 for all other ops.
  - flag_overflow (1 bit): signed overflow for ADD/SUB; 0 for all other ops.
- When undefined, these ports and their logic are absent, and the port list is exactly as above.

Test Plan:
- Reset: hold rst_n=0 with any inputs -> Output=0, flag_zero=1, flag_negative=0. Release, then A=15, B=30, ALUop=AND -> after next edge Output=14, zero=0, neg=0.
- ADD: A=16, B=101 -> Output=117, zero=0, neg=0. Then A=0xFFFF, B=1 -> Output=0, zero=1, carry=1 (with ALU_CARRY_FLAGS_EN).
- SUB: A=44, B=15 -> Output=29. Then A=15, B=30 -> Output=0xFFF1, neg=1. Then A=5, B=5 -> Output=0, zero=1. Then A=0x8000, B=1 -> 0x7FFF, overflow=1 when the macro is defined.
- Logic/shift/pass:
  - OR 0x00F0|0x0F00 = 0x0FF0
  - XOR 0xFFFF^0x00FF = 0xFF00, neg=1
  - SLL 0x0001 by 15 = 0x8000
  - SRL 0x8000 by B=0x0013 (amount 3) = 0x1000
  - PASSB B=0x1234 -> 0x1234
- Back-to-back: change ALUop every cycle across all 8 codes -> each result appears exactly one edge after its inputs; flags stay aligned with Output.
- Mid-operation reset: assert rst_n=0 asynchronously between edges while Output=117 -> Output=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/risc_alu_if.sv
// Execute-stage ALU bus: operands and opcode in, registered result and status flags out.
// Define ALU_CARRY_FLAGS_EN to add the flag_carry and flag_overflow signals.
interface risc_alu_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       ALUop;
    logic [WIDTH-1:0] Output;
    logic             flag_zero;
    logic             flag_negative;
`ifdef ALU_CARRY_FLAGS_EN
    logic             flag_carry;
    logic             flag_overflow;
`endif

    modport master (
        output A, B, ALUop,
`ifdef ALU_CARRY_FLAGS_EN
        input  flag_carry, flag_overflow,
`endif
        input  Output, flag_zero, flag_negative
    );

    modport slave (
        input  A, B, ALUop,
`ifdef ALU_CARRY_FLAGS_EN
        output flag_carry, flag_overflow,
`endif
        output Output, flag_zero, flag_negative
    );
endinterface

// File: rtl/risc_alu.sv
// 16-bit registered ALU, one-cycle latency, eight operations selected by ALUop.
// Optional carry/overflow flags are enabled by defining ALU_CARRY_FLAGS_EN.
module risc_alu #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    risc_alu_if.slave  alu
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SLL   = 3'b101;
    localparam logic [2:0] ALU_SRL   = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_negative;

    // Extra top bit captures carry-out on add and borrow on subtract.
    assign w_sum   = {1'b0, alu.A} + {1'b0, alu.B};
    assign w_diff  = {1'b0, alu.A} - {1'b0, alu.B};
    assign w_shamt = alu.B[SHW-1:0];

    // Operation select.
    always_comb begin
        w_result = '0;
        case (alu.ALUop)
            ALU_AND:   w_result = alu.A & alu.B;
            ALU_ADD:   w_result = w_sum[WIDTH-1:0];
            ALU_SUB:   w_result = w_diff[WIDTH-1:0];
            ALU_OR:    w_result = alu.A | alu.B;
            ALU_XOR:   w_result = alu.A ^ alu.B;
            ALU_SLL:   w_result = alu.A << w_shamt;
            ALU_SRL:   w_result = alu.A >> w_shamt;
            ALU_PASSB: w_result = alu.B;
            default:   w_result = '0;
        endcase
    end

    // Result and flags register together so they always change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_negative <= 1'b0;
        end else begin
            r_result   <= w_result;
            r_zero     <= (w_result == '0);
            r_negative <= w_result[WIDTH-1];
        end
    end

    assign alu.Output        = r_result;
    assign alu.flag_zero     = r_zero;
    assign alu.flag_negative = r_negative;

`ifdef ALU_CARRY_FLAGS_EN
    logic w_carry;
    logic w_overflow;
    logic r_carry;
    logic r_overflow;

    // Carry is NOT borrow on subtract; signed overflow compares operand and result signs.
    always_comb begin
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (alu.ALUop)
            ALU_ADD: begin
                w_carry    = w_sum[WIDTH];
                w_overflow = (alu.A[WIDTH-1] == alu.B[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != alu.A[WIDTH-1]);
            end
            ALU_SUB: begin
                w_carry    = ~w_diff[WIDTH];
                w_overflow = (alu.A[WIDTH-1] != alu.B[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != alu.A[WIDTH-1]);
            end
            default: begin
                w_carry    = 1'b0;
                w_overflow = 1'b0;
            end
        endcase
    end

    // Extended flags share reset and latency with the base flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_carry    <= w_carry;
            r_overflow <= w_overflow;
        end
    end

    assign alu.flag_carry    = r_carry;
    assign alu.flag_overflow = r_overflow;
`endif
endmodule

// File: tb/tb_risc_alu.sv
// Self-checking bench for risc_alu: directed test-plan steps, then random operations
// checked against an arithmetic reference model.
module tb_risc_alu;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    risc_alu_if #(.WIDTH(16)) bus ();

    risc_alu #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .alu   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on unsigned/signed values.
    task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output logic carry, output logic ovf);
        longint ua, ub, sa, sb, r, sr;
        int sh;
        ua = a; ub = b;
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        sh = b % 16;
        carry = 1'b0; ovf = 1'b0; r = 0;
        case (op)
            3'd0: r = a & b;
            3'd1: begin
                r = (ua + ub) % 65536;
                carry = (ua + ub) > 65535;
                sr = sa + sb;
                ovf = (sr > 32767) || (sr < -32768);
            end
            3'd2: begin
                r = (ua - ub + 65536) % 65536;
                carry = (ua >= ub);
                sr = sa - sb;
                ovf = (sr > 32767) || (sr < -32768);
            end
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (ua * (64'd1 << sh)) % 65536;
            3'd6: r = ua / (64'd1 << sh);
            default: r = ub;
        endcase
        res = r[15:0];
    endtask

    task automatic check1(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] exp,
                             input logic exp_c, input logic exp_v);
        check1({tag, ".out"}, 32'(bus.Output), 32'(exp));
        check1({tag, ".zero"}, 32'(bus.flag_zero), 32'(exp == 16'd0));
        check1({tag, ".neg"}, 32'(bus.flag_negative), 32'(exp[15]));
`ifdef ALU_CARRY_FLAGS_EN
        check1({tag, ".carry"}, 32'(bus.flag_carry), 32'(exp_c));
        check1({tag, ".ovf"}, 32'(bus.flag_overflow), 32'(exp_v));
`else
        if (exp_c === 1'bx || exp_v === 1'bx) $display("unused model flag");
`endif
    endtask

    // Drive between edges, sample 1 time unit after the capturing edge.
    task automatic apply(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp,
                         input logic exp_c, input logic exp_v);
        logic [15:0] m;
        logic mc, mv;
        @(negedge clk);
        bus.ALUop = op; bus.A = a; bus.B = b;
        model(op, a, b, m, mc, mv);
        check1({tag, ".model"}, 32'(m), 32'(exp));
        @(posedge clk);
        #1;
        check_out(tag, exp, exp_c, exp_v);
    endtask

    initial begin
        logic [15:0] ra, rb, m;
        logic [2:0]  rop;
        logic mc, mv;
        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0;
        bus.A = 16'h1234; bus.B = 16'h0001; bus.ALUop = 3'd1;

        repeat (3) @(posedge clk);
        #1;
        check_out("reset_hold", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("and",      3'd0, 16'd15,    16'd30,    16'd14,    1'b0, 1'b0);
        apply("add",      3'd1, 16'd16,    16'd101,   16'd117,   1'b0, 1'b0);
        apply("add_wrap", 3'd1, 16'hFFFF,  16'h0001,  16'h0000,  1'b1, 1'b0);
        apply("sub",      3'd2, 16'd44,    16'd15,    16'd29,    1'b1, 1'b0);
        apply("sub_neg",  3'd2, 16'd15,    16'd30,    16'hFFF1,  1'b0, 1'b0);
        apply("sub_zero", 3'd2, 16'd5,     16'd5,     16'h0000,  1'b1, 1'b0);
        apply("sub_ovf",  3'd2, 16'h8000,  16'h0001,  16'h7FFF,  1'b1, 1'b1);
        apply("or",       3'd3, 16'h00F0,  16'h0F00,  16'h0FF0,  1'b0, 1'b0);
        apply("xor",      3'd4, 16'hFFFF,  16'h00FF,  16'hFF00,  1'b0, 1'b0);
        apply("sll15",    3'd5, 16'h0001,  16'h000F,  16'h8000,  1'b0, 1'b0);
        apply("sll0",     3'd5, 16'hA5C3,  16'hFFF0,  16'hA5C3,  1'b0, 1'b0);
        apply("srl3",     3'd6, 16'h8000,  16'h0013,  16'h1000,  1'b0, 1'b0);
        apply("passb",    3'd7, 16'hDEAD,  16'h1234,  16'h1234,  1'b0, 1'b0);
        apply("add_ovf",  3'd1, 16'h7FFF,  16'h0001,  16'h8000,  1'b0, 1'b1);

        // Mid-stream asynchronous reset while Output holds 117.
        apply("add_pre_rst", 3'd1, 16'd16, 16'd101, 16'd117, 1'b0, 1'b0);
        bus.ALUop = 3'd7; bus.B = 16'h5555;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("after_rst", 3'd0, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0);

        // Back-to-back through all eight codes, then random traffic.
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            model(3'(i), ra, rb, m, mc, mv);
            apply($sformatf("b2b_op%0d", i), 3'(i), ra, rb, m, mc, mv);
        end
        for (int i = 0; i < 200; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            if (i % 16 == 0) rb = ra;
            model(rop, ra, rb, m, mc, mv);
            apply($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, m, mc, mv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
